bpb_update_ctrl: RTL and testbench

//  Write-port scheduler for the dual-predict / single-write branch prediction buffer (bpb0).

---
 rtl/bpb_update_ctrl_pkg.sv | 16 +
 rtl/bpb_update_ctrl_fifo.sv | 46 ++++
 rtl/bpb_update_ctrl.sv | 93 +++++++++
 tb/tb_bpb_update_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/bpb_update_ctrl_pkg.sv
// bpb_update_ctrl_pkg: shared types and sizes for the BPB write-port scheduler
package bpb_update_ctrl_pkg;
  typedef logic [31:0] word_t;
  typedef struct packed {
    word_t target;
    logic  taken;
  } bpb_result_t;
  typedef struct packed {
    word_t       pc;
    bpb_result_t result;
  } bpb_update_t;
  typedef enum logic {BPB_RUN, BPB_CLEAR} bpb_ctrl_state_t;
  localparam int BPB_UPD_DEPTH = 4;
  localparam int BPB_ENTRIES = 64;
  localparam int BPB_ENTRY_WIDTH = 6;
endpackage

// File: rtl/bpb_update_ctrl_fifo.sv
// bpb_upd_fifo: 2-write/1-read circular buffer of pending BPB updates
module bpb_upd_fifo
  import bpb_update_ctrl_pkg::*;
#(
  parameter int DEPTH = BPB_UPD_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clr,
  input  logic        we0,
  input  logic        we1,
  input  logic        pop,
  input  bpb_update_t wd0,
  input  bpb_update_t wd1,
  output bpb_update_t rd,
  output logic [AW:0] count
);
  bpb_update_t mem [DEPTH];
  logic [AW-1:0] head, tail, tail1;
  assign tail1 = tail + AW'(we0);
  assign rd = mem[head];
  // entry storage; the second write lands behind the first when both are present
  always_ff @(posedge clk) begin
    if (we0) mem[tail] <= wd0;
    if (we1) mem[tail1] <= wd1;
  end
  // pointers and occupancy; clr discards all queued entries
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (clr) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + AW'(pop);
      tail <= tail + AW'(we0) + AW'(we1);
      count <= count + (AW+1)'(we0) + (AW+1)'(we1) - (AW+1)'(pop);
    end
  end
  // occupancy can never exceed the buffer size
  always @(posedge clk) if (resetn) assert (count <= (AW+1)'(DEPTH));
endmodule

// File: rtl/bpb_update_ctrl.sv
// bpb_update_ctrl: queues dual commit-stage branch updates and drains them into the single BPB write port
module bpb_update_ctrl
  import bpb_update_ctrl_pkg::*;
#(
  parameter int DEPTH = BPB_UPD_DEPTH,
  parameter int ENTRIES = BPB_ENTRIES,
  parameter int ENTRY_W = BPB_ENTRY_WIDTH,
  parameter int CNT_W = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [1:0]             upd_valid,
  input  logic [1:0][31:0]       upd_pc,
  input  bpb_result_t [1:0]      upd_result,
  output logic                   upd_ready,
  input  logic                   flush_req,
  output logic                   clear_busy,
  input  logic                   bpb_stall,
  output logic                   bpb_wen,
  output logic [31:0]            bpb_pc,
  output bpb_result_t            bpb_result,
  output logic [CNT_W-1:0]       drop_cnt
);
  bpb_ctrl_state_t state, state_n;
  logic [ENTRY_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] drop_n;
  logic [CNT_W:0] drop_sum;
  logic [AW:0] count;
  bpb_update_t head, upd0, upd1;
  logic run, coal, en, we0, we1, pop;
  assign run = state == BPB_RUN;
  assign upd_ready = run && count <= (AW+1)'(DEPTH-2);
  assign coal = &upd_valid && upd_pc[0][ENTRY_W+1:2] == upd_pc[1][ENTRY_W+1:2];
  assign en = upd_ready && !flush_req;
  assign we0 = en && upd_valid[0] && !coal;
  assign we1 = en && upd_valid[1];
  assign pop = run && bpb_wen;
  assign upd0 = '{pc: upd_pc[0], result: upd_result[0]};
  assign upd1 = '{pc: upd_pc[1], result: upd_result[1]};
  assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(upd_valid[0]) + (CNT_W+1)'(upd_valid[1]);
  bpb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .clr(run && flush_req),
    .we0(we0),
    .we1(we1),
    .pop(pop),
    .wd0(upd0),
    .wd1(upd1),
    .rd(head),
    .count(count)
  );
  // controller state, sweep index and drop counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= BPB_RUN;
      idx <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      drop_cnt <= drop_n;
    end
  end
  // next state, sweep progress, drop accounting and BPB write port drive
  always_comb begin
    state_n = state;
    idx_n = idx;
    drop_n = drop_cnt;
    bpb_wen = 1'b0;
    bpb_pc = '0;
    bpb_result = '0;
    clear_busy = !run;
    if (run) begin
      bpb_wen = count != '0 && !bpb_stall;
      bpb_pc = bpb_wen ? head.pc : '0;
      bpb_result = bpb_wen ? head.result : '0;
      if (flush_req) begin
        state_n = BPB_CLEAR;
        idx_n = '0;
      end else if (!upd_ready) drop_n = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end else begin
      bpb_wen = !bpb_stall;
      bpb_pc = {{(30-ENTRY_W){1'b0}}, idx, 2'b00};
      if (flush_req) idx_n = '0;
      else if (!bpb_stall) begin
        idx_n = idx + 1'b1;
        if (idx == ENTRY_W'(ENTRIES-1)) state_n = BPB_RUN;
      end
    end
  end
endmodule

// File: tb/tb_bpb_update_ctrl.sv
// tb_bpb_update_ctrl: table-driven and scoreboard checks of the BPB update scheduler
module tb_bpb_update_ctrl;
  import bpb_update_ctrl_pkg::*;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [1:0] upd_valid = '0;
  logic [1:0][31:0] upd_pc = '0;
  bpb_result_t [1:0] upd_result = '0;
  logic upd_ready, flush_req = 1'b0, clear_busy, bpb_stall = 1'b0, bpb_wen;
  logic [31:0] bpb_pc;
  bpb_result_t bpb_result;
  logic [15:0] drop_cnt;
  int checks = 0, passes = 0;
  bpb_update_t exp_q [$];

  typedef struct {
    logic        st;
    logic [1:0]  v;
    logic [31:0] p0, p1;
    logic        t0, t1;
    logic        rdy;
    logic [15:0] drop;
  } vec_t;
  localparam int NV = 19;
  vec_t tbl [NV];

  bpb_update_ctrl dut (
    .clk(clk), .resetn(resetn), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_result(upd_result), .upd_ready(upd_ready), .flush_req(flush_req),
    .clear_busy(clear_busy), .bpb_stall(bpb_stall), .bpb_wen(bpb_wen),
    .bpb_pc(bpb_pc), .bpb_result(bpb_result), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s: got %0h want %0h", n, a, e);
  endtask

  function automatic bpb_update_t mk(input logic [31:0] pc, input logic tk);
    return '{pc: pc, result: '{target: pc + 32'h40, taken: tk}};
  endfunction

  task automatic drive(input vec_t t);
    bpb_stall = t.st;
    upd_valid = t.v;
    upd_pc[0] = t.p0;
    upd_pc[1] = t.p1;
    upd_result[0] = mk(t.p0, t.t0).result;
    upd_result[1] = mk(t.p1, t.t1).result;
  endtask

  task automatic expect_enq(input vec_t t);
    if (t.v == 2'b11 && t.p0[BPB_ENTRY_WIDTH+1:2] == t.p1[BPB_ENTRY_WIDTH+1:2]) exp_q.push_back(mk(t.p1, t.t1));
    else begin
      if (t.v[0]) exp_q.push_back(mk(t.p0, t.t0));
      if (t.v[1]) exp_q.push_back(mk(t.p1, t.t1));
    end
  endtask

  task automatic expect_sweep();
    for (int i = 0; i < BPB_ENTRIES; i++) exp_q.push_back('{pc: 32'(i) << 2, result: '0});
  endtask

  // every BPB write must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (resetn && bpb_wen) begin
      chk("write_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk($sformatf("write_pc%0h", exp_q[0].pc), {bpb_pc, bpb_result}, exp_q.pop_front());
    end
  end

  initial begin
    int n;
    tbl[0]  = '{0, 2'b11, 32'h1000, 32'h1008, 0, 0, 1, 0};
    tbl[1]  = '{0, 2'b00, 32'h0,    32'h0,    0, 0, 1, 0};
    tbl[2]  = '{0, 2'b00, 32'h0,    32'h0,    0, 0, 1, 0};
    tbl[3]  = '{0, 2'b11, 32'h2040, 32'h2040, 0, 1, 1, 0};
    tbl[4]  = '{0, 2'b00, 32'h0,    32'h0,    0, 0, 1, 0};
    tbl[5]  = '{1, 2'b11, 32'h3000, 32'h3004, 1, 0, 1, 0};
    tbl[6]  = '{1, 2'b11, 32'h3010, 32'h3014, 0, 1, 1, 0};
    tbl[7]  = '{1, 2'b11, 32'h3020, 32'h3024, 0, 0, 0, 0};
    tbl[8]  = '{1, 2'b01, 32'h3030, 32'h0,    0, 0, 0, 2};
    tbl[9]  = '{0, 2'b00, 32'h0,    32'h0,    0, 0, 0, 3};
    tbl[10] = '{0, 2'b10, 32'h0,    32'h3040, 0, 0, 0, 3};
    tbl[11] = '{0, 2'b00, 32'h0,    32'h0,    0, 0, 1, 4};
    tbl[12] = '{0, 2'b00, 32'h0,    32'h0,    0, 0, 1, 4};
    tbl[13] = '{0, 2'b10, 32'h0,    32'h4000, 0, 1, 1, 4};
    tbl[14] = '{0, 2'b11, 32'h5000, 32'h5100, 1, 0, 1, 4};
    tbl[15] = '{0, 2'b11, 32'h6000, 32'h6004, 0, 1, 1, 4};
    tbl[16] = '{0, 2'b00, 32'h0,    32'h0,    0, 0, 1, 4};
    tbl[17] = '{0, 2'b00, 32'h0,    32'h0,    0, 0, 1, 4};
    tbl[18] = '{0, 2'b00, 32'h0,    32'h0,    0, 0, 1, 4};
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst_wen", bpb_wen, 0);
    chk("rst_ready", upd_ready, 1);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_busy", clear_busy, 0);
    chk("rst_pc", bpb_pc, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("ready_row%0d", i), upd_ready, tbl[i].rdy);
      chk($sformatf("drop_row%0d", i), drop_cnt, tbl[i].drop);
      @(posedge clk);
      if (tbl[i].rdy) expect_enq(tbl[i]);
      #1;
    end
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_idle", bpb_wen, 0);
    bpb_stall = 1'b1;
    upd_valid = 2'b11;
    upd_pc[0] = 32'h7000;
    upd_pc[1] = 32'h7004;
    @(posedge clk);
    #1 upd_valid = 2'b00;
    flush_req = 1'b1;
    @(negedge clk);
    chk("flush_pre_busy", clear_busy, 0);
    @(posedge clk);
    expect_sweep();
    #1 flush_req = 1'b0;
    bpb_stall = 1'b0;
    upd_valid = 2'b11;
    n = 0;
    for (int k = 0; k < 200 && clear_busy; k++) begin
      bpb_stall = k == 5;
      @(negedge clk);
      if (clear_busy) n++;
      if (k == 0) chk("sweep_ready", upd_ready, 0);
      @(posedge clk);
      #1;
    end
    upd_valid = 2'b00;
    bpb_stall = 1'b0;
    chk("sweep_done", clear_busy, 0);
    chk("sweep_cycles", n, 65);
    chk("sweep_left", exp_q.size(), 0);
    chk("sweep_drop", drop_cnt, 4);
    chk("post_sweep_ready", upd_ready, 1);
    flush_req = 1'b1;
    @(posedge clk);
    expect_sweep();
    #1 flush_req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_wen", bpb_wen, 1);
    chk("mid_pc", bpb_pc, 40);
    resetn = 1'b0;
    #1;
    chk("async_wen", bpb_wen, 0);
    chk("async_busy", clear_busy, 0);
    chk("async_ready", upd_ready, 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rerst_wen", bpb_wen, 0);
    chk("rerst_drop", drop_cnt, 0);
    @(posedge clk);
    #1 flush_req = 1'b1;
    @(posedge clk);
    expect_sweep();
    #1 flush_req = 1'b0;
    for (int k = 0; k < 200 && clear_busy; k++) begin
      @(posedge clk);
      #1;
    end
    chk("resweep_done", clear_busy, 0);
    chk("resweep_left", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
